// File: rtl/mux6_rr_arbiter_pkg.sv
// Shared constants and state type for the 6:1 round-robin arbiter and its data mux.
package mux6_rr_arbiter_pkg;

  localparam int          SEL_W    = 3;
  localparam logic [2:0]  SEL_IDLE = 3'd7;
  localparam int          MAX_REQ  = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Requester index base+off, wrapped into 0..n-1 (off is always < n).
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mux6_rr_arbiter_mux.sv
// Combinational select of one DW-bit requester word; any select at or above N_REQ yields zero.
module data_sel_mux
  import mux6_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = MAX_REQ,
  parameter int DW    = 4
) (
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [N_REQ*DW-1:0] data_flat_i,
  output logic [DW-1:0]       data_o
);

  // NOTE: the default assignment ahead of the loop keeps every path driven, so no latch is inferred.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_i == SEL_W'(i)) data_o = data_flat_i[i*DW +: DW];
    end
  end

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin grant over up to six requesters, one registered output beat under valid/ready.
module mux6_rr_arbiter
  import mux6_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 6,
  parameter int DW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_flat,
  output logic [N_REQ-1:0]    ack,
  output logic [SEL_W-1:0]    sel,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  output logic [7:0]          beat_cnt
);

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [DW-1:0]    out_data_q;
  logic [7:0]       beat_cnt_q;

  logic [SEL_W-1:0] winner;
  logic             found;
  logic             load;
  logic             accept;
  logic [DW-1:0]    mux_data;

  // First set request at or above ptr_q, wrapping past the top requester.
  always_comb begin
    winner = SEL_IDLE;
    found  = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!found && req[SEL_W'(wrap_add(int'(ptr_q), off, N_REQ))]) begin
        found  = 1'b1;
        winner = SEL_W'(wrap_add(int'(ptr_q), off, N_REQ));
      end
    end
  end

  // out_ready only matters while a beat is held; it may reach ack but never out_data.
  assign accept = (state_q == ST_FULL) && out_ready;
  assign load   = ((state_q == ST_EMPTY) || out_ready) && (|req);
  assign ack    = load ? (N_REQ'(1) << winner) : '0;

  data_sel_mux #(
    .N_REQ (N_REQ),
    .DW    (DW)
  ) u_data_sel_mux (
    .sel_i       (winner),
    .data_flat_i (data_flat),
    .data_o      (mux_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is asynchronous; only this handful of flops exists, so clearing all of them is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      sel_q      <= SEL_IDLE;
      out_data_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (accept) beat_cnt_q <= beat_cnt_q + 8'd1;

      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            state_q    <= ST_FULL;
            out_data_q <= mux_data;
            sel_q      <= winner;
            ptr_q      <= (winner == SEL_W'(N_REQ - 1)) ? '0 : winner + SEL_W'(1);
          end
        end
        ST_FULL: begin
          if (load) begin
            out_data_q <= mux_data;
            sel_q      <= winner;
            ptr_q      <= (winner == SEL_W'(N_REQ - 1)) ? '0 : winner + SEL_W'(1);
          end else if (out_ready) begin
            state_q    <= ST_EMPTY;
            sel_q      <= SEL_IDLE;
            out_data_q <= '0;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed bench for mux6_rr_arbiter: hand-computed grants, data, stall, reset and counter wrap.
module tb_mux6_rr_arbiter;

  localparam int N_REQ = 6;
  localparam int DW    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data_flat;
  logic [N_REQ-1:0]    ack;
  logic [2:0]          sel;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_ready;
  logic [7:0]          beat_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux6_rr_arbiter #(
    .N_REQ (N_REQ),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_flat (data_flat),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] s,
                           input logic [3:0] d, input logic [7:0] c);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sel"},   32'(sel),       32'(s));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".cnt"},   32'(beat_cnt),  32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int g;

    rst_n     = 1'b0;
    req       = '0;
    data_flat = '0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("idle", 1'b0, 3'd7, 4'h0, 8'd0);
    end

    // Single request on index 2.
    req       = 6'b000100;
    data_flat = 24'h93A_F17 ^ 24'h000_000;
    data_flat[2*DW +: DW] = 4'hA;
    #1;
    check("single.ack", 32'(ack), 32'(6'b000100));
    step();
    req = '0;
    check_out("single.load", 1'b1, 3'd2, 4'hA, 8'd0);
    #1;
    check("single.noack", 32'(ack), 32'(0));
    step();
    check_out("single.drain", 1'b0, 3'd7, 4'h0, 8'd1);

    // Reset to bring the pointer back to 0.
    rst_n = 1'b0;
    #1;
    check_out("rst1", 1'b0, 3'd7, 4'h0, 8'd0);
    step();
    rst_n = 1'b1;

    // All six requesting, slice i = i+1: grants 0..5,0 back to back.
    req       = 6'b111111;
    data_flat = 24'h654321;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("rr.ack", 32'(ack), 32'(6'b1 << (k % 6)));
      step();
      check_out("rr.out", 1'b1, 3'(k % 6), 4'((k % 6) + 1), 8'(k));
    end
    // Grants 1, 2, 3 -> FULL with sel=3, ptr=4, beat_cnt=9.
    for (int k = 1; k <= 3; k++) begin
      step();
      check_out("rr.more", 1'b1, 3'(k), 4'(k + 1), 8'(6 + k));
    end

    // Stall five cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall.ack", 32'(ack), 32'(0));
      step();
      check_out("stall.out", 1'b1, 3'd3, 4'h4, 8'd9);
    end
    out_ready = 1'b1;
    #1;
    check("release.ack", 32'(ack), 32'(6'b010000));
    step();
    check_out("release.out", 1'b1, 3'd4, 4'h5, 8'd10);

    // Grants 5,0,1,2,3 -> sel=3, ptr=4 again.
    exp_cnt = 10;
    for (int k = 0; k < 5; k++) begin
      g = (5 + k) % 6;
      step();
      exp_cnt++;
      check_out("refill", 1'b1, 3'(g), 4'(g + 1), 8'(exp_cnt));
    end

    // Asynchronous reset while FULL with ptr=4.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst2", 1'b0, 3'd7, 4'h0, 8'd0);
    step();
    req       = 6'b110001;
    data_flat = 24'hEDCBA7;
    rst_n     = 1'b1;
    #1;
    check("post_rst.ack", 32'(ack), 32'(6'b000001));
    step();
    check_out("post_rst.out", 1'b1, 3'd0, 4'h7, 8'd0);

    // 256 accepted beats wrap the counter back to zero.
    req = 6'b111111;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 255) check("wrap.255", 32'(beat_cnt), 32'd255);
    end
    check("wrap.0", 32'(beat_cnt), 32'd0);
    check("wrap.valid", 32'(out_valid), 32'd1);

    // Drain with no requests: FULL -> EMPTY.
    req = '0;
    step();
    check_out("drain", 1'b0, 3'd7, 4'h0, 8'd1);

    // out_ready is ignored while EMPTY.
    out_ready = 1'b0;
    req       = 6'b000010;
    data_flat = 24'h0000C0;
    #1;
    check("empty_nrdy.ack", 32'(ack), 32'(6'b000010));
    step();
    req = '0;
    check_out("empty_nrdy.out", 1'b1, 3'd1, 4'hC, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
